// File: rtl/ntt_pkg.sv
// Shared types and arithmetic helpers for the NTT stage sequencer.
// Latency: n/a (constants, types and pure functions only).
// Backpressure: n/a.
package ntt_pkg;

    localparam int WIDTH    = 32;
    localparam int LUT_SIZE = 1360;
    localparam int ADDR_W   = 8;
    localparam int CNT_W    = 9;
    localparam int RD_LAT   = 1;
    localparam int BF_LAT   = 6;
    localparam int W_IDX_W  = $clog2(LUT_SIZE);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_FINISH
    } state_t;

    // Cycles from a read strobe to the matching butterfly result.
    function automatic int total_lat(input int rd_lat, input int bf_lat);
        return rd_lat + bf_lat;
    endfunction

    // Vector address of op k: base + k*stride, wrapping modulo 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] addr_at(input logic [ADDR_W-1:0] base,
                                                  input logic [ADDR_W-1:0] stride,
                                                  input logic [CNT_W-1:0]  k);
        logic [ADDR_W+CNT_W-1:0] prod;
        prod = {{CNT_W{1'b0}}, stride} * {{ADDR_W{1'b0}}, k};
        return base + prod[ADDR_W-1:0];
    endfunction

    // Next twiddle row; wraps from LUT_SIZE-1 back to row 0.
    function automatic logic [W_IDX_W-1:0] w_next(input logic [W_IDX_W-1:0] idx);
        return (idx == W_IDX_W'(LUT_SIZE - 1)) ? '0 : idx + 1'b1;
    endfunction

endpackage

// File: rtl/ntt_valid_delay.sv
// Shift register that delays the issue-valid bit to the write-back point.
// Latency: exactly DEPTH cycles from in_vld to out_vld.
// Backpressure: none; one bit in and one bit out every cycle.
module ntt_valid_delay
    import ntt_pkg::*;
#(
    parameter int DEPTH = total_lat(RD_LAT, BF_LAT)
) (
    input  logic clk,
    input  logic reset,
    input  logic in_vld,
    output logic out_vld
);

    logic [DEPTH-1:0] sr_q;
    logic [DEPTH-1:0] sr_d;

    // Shift the new valid bit in at stage 0.
    always_comb begin
        sr_d    = sr_q << 1;
        sr_d[0] = in_vld;
    end

    // Reset drops every in-flight valid so an abandoned operation retires nothing.
    always_ff @(posedge clk) begin
        if (reset) sr_q <= '0;
        else       sr_q <= sr_d;
    end

    assign out_vld = sr_q[DEPTH-1];

endmodule

// File: rtl/butterfly_stage_sequencer.sv
// Issues one NTT stage of butterfly/multiply reads and retires the write-backs.
// Latency: start to done = count + RD_LAT + BF_LAT + 1 cycles (1 cycle when count = 0).
// Backpressure: none; start is ignored unless IDLE, ops issue one per cycle without stalls.
module butterfly_stage_sequencer
    import ntt_pkg::*;
#(
    parameter int RD_LAT_CYC = RD_LAT,
    parameter int BF_LAT_CYC = BF_LAT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               cfg_mode,
    input  logic               cfg_swap,
    input  logic [CNT_W-1:0]   cfg_count,
    input  logic [ADDR_W-1:0]  cfg_a_base,
    input  logic [ADDR_W-1:0]  cfg_b_base,
    input  logic [ADDR_W-1:0]  cfg_stride,
    input  logic [W_IDX_W-1:0] cfg_w_base,
    output logic               busy,
    output logic               done,
    output logic               rd_en,
    output logic [ADDR_W-1:0]  rd_addr_a,
    output logic [ADDR_W-1:0]  rd_addr_b,
    output logic [W_IDX_W-1:0] w_idx,
    output logic               bf_mode,
    output logic               bf_swap,
    output logic               wr_en,
    output logic [ADDR_W-1:0]  wr_addr_a,
    output logic [ADDR_W-1:0]  wr_addr_b
);

    localparam int TOTAL_LAT = total_lat(RD_LAT_CYC, BF_LAT_CYC);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [ADDR_W-1:0]   a_base_q, a_base_d;
    logic [ADDR_W-1:0]   b_base_q, b_base_d;
    logic [ADDR_W-1:0]   stride_q, stride_d;
    logic [CNT_W-1:0]    iss_k_q, iss_k_d;
    logic [CNT_W-1:0]    ret_k_q, ret_k_d;
    logic                rd_en_q, rd_en_d;
    logic [ADDR_W-1:0]   rd_addr_a_q, rd_addr_a_d;
    logic [ADDR_W-1:0]   rd_addr_b_q, rd_addr_b_d;
    logic [W_IDX_W-1:0]  w_idx_q, w_idx_d;
    logic                bf_mode_q, bf_mode_d;
    logic                bf_swap_q, bf_swap_d;
    logic [ADDR_W-1:0]   wr_addr_a_q, wr_addr_a_d;
    logic [ADDR_W-1:0]   wr_addr_b_q, wr_addr_b_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [CNT_W-1:0]    last_k;
    logic                wr_vld;

    assign last_k = count_q - CNT_W'(1);

    // Issue valid, delayed by the full read + butterfly latency, becomes wr_en.
    ntt_valid_delay #(
        .DEPTH (TOTAL_LAT)
    ) u_valid_delay (
        .clk     (clk),
        .reset   (reset),
        .in_vld  (rd_en_q),
        .out_vld (wr_vld)
    );

    // Next-state, issue/retire counters and registered-output values.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        a_base_d  = a_base_q;
        b_base_d  = b_base_q;
        stride_d  = stride_q;
        iss_k_d   = iss_k_q;
        ret_k_d   = ret_k_q;
        w_idx_d   = w_idx_q;
        bf_mode_d = bf_mode_q;
        bf_swap_d = bf_swap_q;

        // Retire counter runs independently of the issue side.
        if (wr_vld) ret_k_d = ret_k_q + 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    count_d   = cfg_count;
                    a_base_d  = cfg_a_base;
                    b_base_d  = cfg_b_base;
                    stride_d  = cfg_stride;
                    bf_mode_d = cfg_mode;
                    bf_swap_d = cfg_swap;
                    iss_k_d   = '0;
                    ret_k_d   = '0;
                    w_idx_d   = cfg_w_base;
                    state_d   = (cfg_count != '0) ? ST_ISSUE : ST_FINISH;
                end
            end
            ST_ISSUE: begin
                if (iss_k_q == last_k) begin
                    state_d = ST_DRAIN;
                end else begin
                    iss_k_d = iss_k_q + 1'b1;
                    w_idx_d = w_next(w_idx_q);
                end
            end
            ST_DRAIN: begin
                if (wr_vld && (ret_k_q == last_k)) state_d = ST_FINISH;
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        rd_en_d     = (state_d == ST_ISSUE);
        busy_d      = (state_d == ST_ISSUE) || (state_d == ST_DRAIN);
        done_d      = (state_d == ST_FINISH);
        rd_addr_a_d = addr_at(a_base_d, stride_d, iss_k_d);
        rd_addr_b_d = addr_at(b_base_d, stride_d, iss_k_d);
        wr_addr_a_d = addr_at(a_base_d, stride_d, ret_k_d);
        wr_addr_b_d = addr_at(b_base_d, stride_d, ret_k_d);
    end

    // FSM state, latched configuration and all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            a_base_q    <= '0;
            b_base_q    <= '0;
            stride_q    <= '0;
            iss_k_q     <= '0;
            ret_k_q     <= '0;
            rd_en_q     <= 1'b0;
            rd_addr_a_q <= '0;
            rd_addr_b_q <= '0;
            w_idx_q     <= '0;
            bf_mode_q   <= 1'b0;
            bf_swap_q   <= 1'b0;
            wr_addr_a_q <= '0;
            wr_addr_b_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            a_base_q    <= a_base_d;
            b_base_q    <= b_base_d;
            stride_q    <= stride_d;
            iss_k_q     <= iss_k_d;
            ret_k_q     <= ret_k_d;
            rd_en_q     <= rd_en_d;
            rd_addr_a_q <= rd_addr_a_d;
            rd_addr_b_q <= rd_addr_b_d;
            w_idx_q     <= w_idx_d;
            bf_mode_q   <= bf_mode_d;
            bf_swap_q   <= bf_swap_d;
            wr_addr_a_q <= wr_addr_a_d;
            wr_addr_b_q <= wr_addr_b_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign rd_en     = rd_en_q;
    assign rd_addr_a = rd_addr_a_q;
    assign rd_addr_b = rd_addr_b_q;
    assign w_idx     = w_idx_q;
    assign bf_mode   = bf_mode_q;
    assign bf_swap   = bf_swap_q;
    assign wr_en     = wr_vld;
    assign wr_addr_a = wr_addr_a_q;
    assign wr_addr_b = wr_addr_b_q;

endmodule

// File: tb/tb_butterfly_stage_sequencer.sv
// Directed bench for butterfly_stage_sequencer with a read/write/done scoreboard.
// Latency: expected read at start+1+k, write at start+8+k, done at start+count+8.
// Backpressure: n/a; the DUT never stalls, so every event is timed to the cycle.
module tb_butterfly_stage_sequencer;
    import ntt_pkg::*;

    localparam int TL = 7;

    typedef struct {
        int cyc;
        int a;
        int b;
        int w;
    } rec_t;

    logic               clk;
    logic               reset;
    logic               start;
    logic               cfg_mode;
    logic               cfg_swap;
    logic [CNT_W-1:0]   cfg_count;
    logic [ADDR_W-1:0]  cfg_a_base;
    logic [ADDR_W-1:0]  cfg_b_base;
    logic [ADDR_W-1:0]  cfg_stride;
    logic [W_IDX_W-1:0] cfg_w_base;
    logic               busy;
    logic               done;
    logic               rd_en;
    logic [ADDR_W-1:0]  rd_addr_a;
    logic [ADDR_W-1:0]  rd_addr_b;
    logic [W_IDX_W-1:0] w_idx;
    logic               bf_mode;
    logic               bf_swap;
    logic               wr_en;
    logic [ADDR_W-1:0]  wr_addr_a;
    logic [ADDR_W-1:0]  wr_addr_b;

    int   vectors;
    int   miscompares;
    int   cyc;
    int   busy_from;
    int   busy_to;
    int   rst_cyc;
    bit   mon_on;
    logic exp_mode;
    logic exp_swap;
    rec_t rd_q[$];
    rec_t wr_q[$];
    int   done_q[$];
    rec_t mr;
    rec_t mw;
    int   md;

    butterfly_stage_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .cfg_mode   (cfg_mode),
        .cfg_swap   (cfg_swap),
        .cfg_count  (cfg_count),
        .cfg_a_base (cfg_a_base),
        .cfg_b_base (cfg_b_base),
        .cfg_stride (cfg_stride),
        .cfg_w_base (cfg_w_base),
        .busy       (busy),
        .done       (done),
        .rd_en      (rd_en),
        .rd_addr_a  (rd_addr_a),
        .rd_addr_b  (rd_addr_b),
        .w_idx      (w_idx),
        .bf_mode    (bf_mode),
        .bf_swap    (bf_swap),
        .wr_en      (wr_en),
        .wr_addr_a  (wr_addr_a),
        .wr_addr_b  (wr_addr_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives a one-cycle start; when accepted, pushes the reference events.
    task automatic start_op(input logic m, input logic s, input int cnt, input int a,
                            input int b, input int st, input int w, input bit accept);
        int t0;
        cfg_mode   = m;
        cfg_swap   = s;
        cfg_count  = CNT_W'(cnt);
        cfg_a_base = ADDR_W'(a);
        cfg_b_base = ADDR_W'(b);
        cfg_stride = ADDR_W'(st);
        cfg_w_base = W_IDX_W'(w);
        start      = 1'b1;
        t0         = cyc;
        if (accept) begin
            exp_mode = m;
            exp_swap = s;
            for (int k = 0; k < cnt; k++) begin
                rd_q.push_back('{t0 + 1 + k, (a + k * st) % 256, (b + k * st) % 256, (w + k) % 1360});
                wr_q.push_back('{t0 + 1 + k + TL, (a + k * st) % 256, (b + k * st) % 256, (w + k) % 1360});
            end
            done_q.push_back((cnt == 0) ? t0 + 1 : t0 + cnt + TL + 1);
            busy_from = t0 + 1;
            busy_to   = (cnt == 0) ? t0 : t0 + cnt + TL;
        end
        @(posedge clk);
        #1;
        start      = 1'b0;
        cfg_mode   = 1'($urandom);
        cfg_swap   = 1'($urandom);
        cfg_count  = CNT_W'($urandom);
        cfg_a_base = ADDR_W'($urandom);
        cfg_b_base = ADDR_W'($urandom);
        cfg_stride = ADDR_W'($urandom);
        cfg_w_base = W_IDX_W'($urandom_range(0, 1359));
    endtask

    task automatic chk_drained(input string tag);
        chk({tag, "_rd_left"}, 32'(rd_q.size()), 0);
        chk({tag, "_wr_left"}, 32'(wr_q.size()), 0);
        chk({tag, "_done_left"}, 32'(done_q.size()), 0);
    endtask

    // Scoreboard: compare every DUT event against the head of its queue.
    always @(negedge clk) begin
        if (mon_on) begin
            chk("busy", 32'(busy), 32'((cyc >= busy_from && cyc <= busy_to) ? 1 : 0));
            if (rd_en !== 1'b0) begin
                chk("rd_en_expected", 32'(rd_q.size() != 0), 1);
                if (rd_q.size() != 0) begin
                    mr = rd_q.pop_front();
                    chk("rd_cycle", cyc, mr.cyc);
                    chk("rd_addr_a", 32'(rd_addr_a), mr.a);
                    chk("rd_addr_b", 32'(rd_addr_b), mr.b);
                    chk("w_idx", 32'(w_idx), mr.w);
                    chk("rd_bf_mode", 32'(bf_mode), 32'(exp_mode));
                    chk("rd_bf_swap", 32'(bf_swap), 32'(exp_swap));
                end
            end
            if (wr_en !== 1'b0) begin
                chk("wr_en_expected", 32'(wr_q.size() != 0), 1);
                if (wr_q.size() != 0) begin
                    mw = wr_q.pop_front();
                    chk("wr_cycle", cyc, mw.cyc);
                    chk("wr_addr_a", 32'(wr_addr_a), mw.a);
                    chk("wr_addr_b", 32'(wr_addr_b), mw.b);
                    chk("wr_bf_mode", 32'(bf_mode), 32'(exp_mode));
                    chk("wr_bf_swap", 32'(bf_swap), 32'(exp_swap));
                end
            end
            if (done !== 1'b0) begin
                chk("done_expected", 32'(done_q.size() != 0), 1);
                if (done_q.size() != 0) begin
                    md = done_q.pop_front();
                    chk("done_cycle", cyc, md);
                end
            end
        end
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        cyc         = 0;
        busy_from   = -1;
        busy_to     = -2;
        mon_on      = 1'b0;
        exp_mode    = 1'b0;
        exp_swap    = 1'b0;
        reset       = 1'b1;
        start       = 1'b0;
        cfg_mode    = 1'b0;
        cfg_swap    = 1'b0;
        cfg_count   = '0;
        cfg_a_base  = '0;
        cfg_b_base  = '0;
        cfg_stride  = '0;
        cfg_w_base  = '0;

        // Reset state.
        wait_cycles(3);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_rd_en", 32'(rd_en), 0);
        chk("rst_wr_en", 32'(wr_en), 0);
        chk("rst_w_idx", 32'(w_idx), 0);
        chk("rst_bf_mode", 32'(bf_mode), 0);
        reset  = 1'b0;
        mon_on = 1'b1;
        wait_cycles(2);

        // Basic timing: 4 butterflies, unit stride.
        start_op(1'b0, 1'b0, 4, 0, 64, 1, 10, 1'b1);
        wait_cycles(16);
        chk_drained("basic");

        // Empty operation.
        start_op(1'b0, 1'b0, 0, 5, 6, 1, 3, 1'b1);
        wait_cycles(6);
        chk_drained("empty");

        // Address and twiddle-index wrap.
        start_op(1'b0, 1'b0, 3, 254, 10, 1, 1358, 1'b1);
        wait_cycles(14);
        chk_drained("wrap");

        // Multiply/swap held while a second start arrives mid-issue.
        start_op(1'b1, 1'b1, 6, 16, 32, 3, 100, 1'b1);
        wait_cycles(2);
        start_op(1'b0, 1'b0, 2, 200, 210, 5, 7, 1'b0);
        wait_cycles(20);
        chk_drained("modehold");

        // Reset in the cycle after op 2 issues.
        start_op(1'b0, 1'b0, 8, 8, 40, 2, 500, 1'b1);
        wait_cycles(3);
        reset   = 1'b1;
        rst_cyc = cyc;
        wait_cycles(1);
        reset   = 1'b0;
        rd_q.delete();
        wr_q.delete();
        done_q.delete();
        busy_to = rst_cyc;
        @(negedge clk);
        chk("mrst_busy", 32'(busy), 0);
        chk("mrst_done", 32'(done), 0);
        chk("mrst_rd_en", 32'(rd_en), 0);
        chk("mrst_wr_en", 32'(wr_en), 0);
        chk("mrst_rd_addr_a", 32'(rd_addr_a), 0);
        chk("mrst_rd_addr_b", 32'(rd_addr_b), 0);
        chk("mrst_w_idx", 32'(w_idx), 0);
        chk("mrst_wr_addr_a", 32'(wr_addr_a), 0);
        chk("mrst_wr_addr_b", 32'(wr_addr_b), 0);
        chk("mrst_bf_mode", 32'(bf_mode), 0);
        @(posedge clk);
        #1;
        wait_cycles(15);
        start_op(1'b1, 1'b0, 2, 100, 120, 4, 1359, 1'b1);
        wait_cycles(14);
        chk_drained("after_reset");

        // Back-to-back: second start in the cycle right after done.
        start_op(1'b0, 1'b1, 3, 30, 60, 7, 20, 1'b1);
        wait_cycles(11);
        start_op(1'b1, 1'b0, 3, 31, 61, 7, 21, 1'b1);
        wait_cycles(16);
        chk_drained("b2b");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
